// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one main-memory block port between the
// instruction cache (read-only) and the data cache (read/write). Each cache
// sees the same busywait handshake it would get from a private memory.
module mem_port_arbiter #(
  parameter int AW = 6,
  parameter int BW = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_mem_read,
  input  logic [AW-1:0] i_mem_address,
  output logic [BW-1:0] i_mem_readdata,
  output logic          i_mem_busywait,
  input  logic          d_mem_read,
  input  logic          d_mem_write,
  input  logic [AW-1:0] d_mem_address,
  input  logic [BW-1:0] d_mem_writedata,
  output logic [BW-1:0] d_mem_readdata,
  output logic          d_mem_busywait,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [BW-1:0] mem_writedata,
  input  logic [BW-1:0] mem_readdata,
  input  logic          mem_busywait
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  state_t state;
  state_t next_state;
  logic   seen_busy;
  logic   last_grant;
  logic   req_i;
  logic   req_d;
  logic   done;

  assign req_i = i_mem_read;
  assign req_d = d_mem_read | d_mem_write;

  // Completion only counts once memory has been observed busy in this grant.
  assign done = seen_busy & ~mem_busywait;

  // Read data is shared; each cache only captures on its own completion.
  assign i_mem_readdata = mem_readdata;
  assign d_mem_readdata = mem_readdata;

  // State register; reset drops any grant immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Track memory-busy history per grant and remember who was served last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_busy  <= 1'b0;
      last_grant <= SRC_I;
    end else if (state == IDLE) begin
      seen_busy <= 1'b0;
      if (next_state == GRANT_I) begin
        last_grant <= SRC_I;
      end else if (next_state == GRANT_D) begin
        last_grant <= SRC_D;
      end
    end else if (next_state == IDLE) begin
      seen_busy <= 1'b0;
    end else if (mem_busywait) begin
      seen_busy <= 1'b1;
    end
  end

  // Arbitration, memory command steering and per-cache stall generation.
  always_comb begin
    next_state     = state;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    i_mem_busywait = req_i;
    d_mem_busywait = req_d;
    case (state)
      IDLE: begin
        if (req_i && req_d) begin
          next_state = (last_grant == SRC_I) ? GRANT_D : GRANT_I;
        end else if (req_i) begin
          next_state = GRANT_I;
        end else if (req_d) begin
          next_state = GRANT_D;
        end
      end
      GRANT_I: begin
        mem_read       = i_mem_read;
        mem_address    = i_mem_address;
        i_mem_busywait = ~done;
        if (done || (!req_i && !seen_busy)) begin
          next_state = IDLE;
        end
      end
      GRANT_D: begin
        mem_write      = d_mem_write;
        mem_read       = d_mem_read & ~d_mem_write;
        mem_address    = d_mem_address;
        mem_writedata  = d_mem_writedata;
        d_mem_busywait = ~done;
        if (done || (!req_d && !seen_busy)) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 6;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_mem_read = 1'b0;
  logic [AW-1:0] i_mem_address = '0;
  logic [BW-1:0] i_mem_readdata;
  logic          i_mem_busywait;
  logic          d_mem_read = 1'b0;
  logic          d_mem_write = 1'b0;
  logic [AW-1:0] d_mem_address = '0;
  logic [BW-1:0] d_mem_writedata = '0;
  logic [BW-1:0] d_mem_readdata;
  logic          d_mem_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_writedata;
  logic [BW-1:0] mem_readdata = '0;
  logic          mem_busywait = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: who currently owns the port (0 none, 1 I, 2 D),
  // who was served most recently, and whether memory has shown busy yet.
  int holder = 0;
  int last_served = 1;
  bit seen = 1'b0;
  int grant_log[$];

  mem_port_arbiter #(.AW(AW), .BW(BW)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_mem_read      (i_mem_read),
    .i_mem_address   (i_mem_address),
    .i_mem_readdata  (i_mem_readdata),
    .i_mem_busywait  (i_mem_busywait),
    .d_mem_read      (d_mem_read),
    .d_mem_write     (d_mem_write),
    .d_mem_address   (d_mem_address),
    .d_mem_writedata (d_mem_writedata),
    .d_mem_readdata  (d_mem_readdata),
    .d_mem_busywait  (d_mem_busywait),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_busywait    (mem_busywait)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    holder      = 0;
    last_served = 1;
    seen        = 1'b0;
  endtask

  task automatic check_output();
    logic          req_i, req_d, done;
    logic          e_rd, e_wr, e_ib, e_db;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_wd;
    req_i  = i_mem_read;
    req_d  = d_mem_read || d_mem_write;
    done   = seen && !mem_busywait;
    e_rd   = 1'b0;
    e_wr   = 1'b0;
    e_addr = '0;
    e_wd   = '0;
    e_ib   = req_i;
    e_db   = req_d;
    if (holder == 1) begin
      e_rd   = i_mem_read;
      e_addr = i_mem_address;
      e_ib   = !done;
    end else if (holder == 2) begin
      e_wr   = d_mem_write;
      e_rd   = d_mem_read && !d_mem_write;
      e_addr = d_mem_address;
      e_wd   = d_mem_writedata;
      e_db   = !done;
    end
    check_value("mem_read", BW'(mem_read), BW'(e_rd));
    check_value("mem_write", BW'(mem_write), BW'(e_wr));
    check_value("mem_address", BW'(mem_address), BW'(e_addr));
    check_value("mem_writedata", mem_writedata, e_wd);
    check_value("i_mem_busywait", BW'(i_mem_busywait), BW'(e_ib));
    check_value("d_mem_busywait", BW'(d_mem_busywait), BW'(e_db));
    check_value("i_mem_readdata", i_mem_readdata, mem_readdata);
    check_value("d_mem_readdata", d_mem_readdata, mem_readdata);
  endtask

  // Apply the arbitration and completion rules for one clock edge.
  task automatic advance_model();
    bit req_i, req_d, owner_req;
    req_i = i_mem_read;
    req_d = d_mem_read || d_mem_write;
    if (holder == 0) begin
      if (req_i && req_d) holder = (last_served == 1) ? 2 : 1;
      else if (req_i)     holder = 1;
      else if (req_d)     holder = 2;
      if (holder != 0) begin
        last_served = holder;
        seen        = 1'b0;
        grant_log.push_back(holder);
      end
    end else begin
      owner_req = (holder == 1) ? req_i : req_d;
      if (seen && !mem_busywait)     holder = 0;
      else if (!owner_req && !seen)  holder = 0;
      else if (mem_busywait)         seen = 1'b1;
    end
  endtask

  task automatic apply_stimulus(input logic ir, input logic [AW-1:0] ia, input logic dr,
                                input logic dw, input logic [AW-1:0] da, input logic [BW-1:0] dwd);
    i_mem_read      = ir;
    i_mem_address   = ia;
    d_mem_read      = dr;
    d_mem_write     = dw;
    d_mem_address   = da;
    d_mem_writedata = dwd;
  endtask

  // One clock: drive memory busy, check at negedge, advance model at posedge.
  task automatic run_cycle(input logic busy);
    mem_busywait = busy;
    @(negedge clk);
    check_output();
    @(posedge clk);
    advance_model();
    #1;
  endtask

  task automatic transaction(input int busy_cycles);
    run_cycle(1'b0);
    repeat (busy_cycles) run_cycle(1'b1);
    run_cycle(1'b0);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();

    // Reset then idle
    #12;
    check_output();
    #4;
    reset = 1'b1;
    repeat (3) run_cycle(1'b0);

    // Single I miss with a five-cycle memory
    $display("[TB] single instruction miss");
    mem_readdata = {16{8'hA5}};
    apply_stimulus(1'b1, 6'h15, 1'b0, 1'b0, '0, '0);
    run_cycle(1'b0);
    check_value("t2_mem_read", BW'(mem_read), BW'(1'b1));
    check_value("t2_mem_address", BW'(mem_address), BW'(6'h15));
    repeat (5) run_cycle(1'b1);
    mem_busywait = 1'b0;
    #1;
    check_value("t2_busy_drop", BW'(i_mem_busywait), BW'(1'b0));
    check_value("t2_readdata", i_mem_readdata, {16{8'hA5}});
    run_cycle(1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    run_cycle(1'b0);

    // D write-back
    $display("[TB] data write-back");
    apply_stimulus(1'b0, '0, 1'b0, 1'b1, 6'h2A, BW'(16'h1234));
    run_cycle(1'b0);
    check_value("t3_mem_write", BW'(mem_write), BW'(1'b1));
    check_value("t3_mem_writedata", mem_writedata, BW'(16'h1234));
    repeat (3) run_cycle(1'b1);
    run_cycle(1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    run_cycle(1'b0);

    // Simultaneous requests after reset alternate D, I, D, I
    $display("[TB] sustained dual requests");
    reset_pulse();
    grant_log.delete();
    apply_stimulus(1'b1, 6'h15, 1'b1, 1'b0, 6'h3F, '0);
    repeat (4) transaction(2);
    check_value("t4_grant_count", BW'(grant_log.size()), BW'(4));
    for (int k = 0; k < 4; k++) begin
      check_value("t4_grant_order", BW'(grant_log[k]), BW'((k % 2 == 0) ? 2 : 1));
    end
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    run_cycle(1'b0);

    // Async reset in the middle of an I grant
    $display("[TB] reset during grant");
    apply_stimulus(1'b1, 6'h07, 1'b0, 1'b0, '0, '0);
    run_cycle(1'b0);
    run_cycle(1'b1);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_value("t5_mem_read_abort", BW'(mem_read), BW'(1'b0));
    check_value("t5_addr_abort", BW'(mem_address), BW'(0));
    check_value("t5_i_stall", BW'(i_mem_busywait), BW'(1'b1));
    check_output();
    #1;
    reset = 1'b1;
    grant_log.delete();
    run_cycle(1'b0);
    check_value("t5_regrant", BW'(grant_log.size() == 1 && grant_log[0] == 1), BW'(1'b1));
    check_value("t5_regrant_read", BW'(mem_read), BW'(1'b1));
    run_cycle(1'b1);
    run_cycle(1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    run_cycle(1'b0);

    // Memory late to raise busy: no premature completion
    $display("[TB] late memory busy");
    apply_stimulus(1'b1, 6'h01, 1'b0, 1'b0, '0, '0);
    run_cycle(1'b0);
    run_cycle(1'b0);
    check_value("t6_still_stalled", BW'(i_mem_busywait), BW'(1'b1));
    check_value("t6_still_reading", BW'(mem_read), BW'(1'b1));
    repeat (3) run_cycle(1'b1);
    run_cycle(1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    run_cycle(1'b0);

    // Random traffic including mid-grant request drops
    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      mem_readdata = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(($urandom % 3) != 0, AW'($urandom), ($urandom % 3) == 0,
                     ($urandom % 4) == 0, AW'($urandom),
                     {$urandom, $urandom, $urandom, $urandom});
      run_cycle(($urandom % 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory block port between the instruction cache (read-only requester I) and the data cache (read/write requester D).
- Sits between both cache controllers' mem_* interfaces and the main memory.
- Grants one requester at a time, holds the grant until the memory completes, and rotates priority (round-robin) so neither cache starves.
- Presents each cache with the same busywait handshake it would see from a private memory.

Parameters:
- AW, 6, block address width (tag+index).
- BW, 128, block data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- i_mem_read  in  1  instruction cache block read request.
- i_mem_address  in  AW  instruction cache block address.
- i_mem_readdata  out  BW  block data returned to the instruction cache.
- i_mem_busywait  out  1  stall to the instruction cache.
- d_mem_read  in  1  data cache block read request.
- d_mem_write  in  1  data cache block write-back request.
- d_mem_address  in  AW  data cache block address.
- d_mem_writedata  in  BW  data cache write-back block.
- d_mem_readdata  out  BW  block data returned to the data cache.
- d_mem_busywait  out  1  stall to the data cache.
- mem_read  out  1  read command to memory.
- mem_write  out  1  write command to memory.
- mem_address  out  AW  address to memory.
- mem_writedata  out  BW  write data to memory.
- mem_readdata  in  BW  block from memory.
- mem_busywait  in  1  memory busy; high while an operation is in progress.

Behaviour:
- States:
  - IDLE, GRANT_I, GRANT_D.
  - State register, seen_busy flag and last_grant pointer are posedge-clocked and asynchronously reset.
- Reset (reset=0), asynchronously:
  - state=IDLE, seen_busy=0, last_grant=I (so D wins the first tie).
  - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
  - i_mem_busywait and d_mem_busywait follow the IDLE equations below, so they read 0 when no request is pending.
- Request definitions: reqI = i_mem_read; reqD = d_mem_read | d_mem_write.
- IDLE:
  - No memory command is driven.
  - x_busywait = reqx, combinational.
  - Next-state selection at the posedge:
    - Only reqI: go to GRANT_I.
    - Only reqD: go to GRANT_D.
    - Both requesting: grant the requester not equal to last_grant.
    - Neither requesting: remain in IDLE.
  - On entering a grant: last_grant updates to the granted requester and seen_busy clears.
- GRANT_x:
  - Memory outputs are driven combinationally from requester x's inputs.
  - For I: mem_read = i_mem_read, mem_write = 0.
  - For D: mem_write = d_mem_write; mem_read = d_mem_read & ~d_mem_write. Write takes precedence if both are high.
  - seen_busy sets at any posedge where mem_busywait=1.
- Completion:
  - done = seen_busy & ~mem_busywait.
  - Granted x_busywait = ~done.
  - Non-granted requester's busywait = its req, i.e. stalled.
  - At the posedge where done=1, the state returns to IDLE. The cache sees busywait=0 on the same edge, leaves its memory-read state and drops its request.
  - A new arbitration therefore takes a minimum of 1 IDLE cycle after each completion.
- Latency: grant is 1 cycle after the request, then memory latency, then 1 IDLE cycle. Back-to-back alternation I→D→I is guaranteed when both requesters request continuously.
- Readdata: i_mem_readdata = d_mem_readdata = mem_readdata, pass-through. Each cache captures only on its own completion.
- Requester drops its request mid-grant (protocol violation):
  - The memory command deasserts with it.
  - If seen_busy=1, the arbiter still waits for done.
  - If seen_busy=0, the arbiter returns to IDLE at the next posedge.
- Memory must raise mem_busywait within the first grant cycle. Until seen_busy is set, a low mem_busywait is not treated as completion.
- Reset asserted mid-operation: command outputs drop immediately and state goes to IDLE. Memory-side abort is the memory's responsibility.

Test Plan:
1. Reset then idle: reset=0 at t=0 and released; no requests → mem_read=mem_write=0, both busywaits 0, state IDLE.
2. Single I miss: i_mem_read=1, i_mem_address=6'h15; memory busy 5 cycles, returns 128'hA5..A5 → mem_read=1 with mem_address=6'h15 from cycle 1; i_mem_busywait=1 until done; i_mem_readdata=128'hA5..A5 at the done edge; then IDLE.
3. D write-back: d_mem_write=1, addr 6'h2A, writedata 128'h1234 → mem_write=1, mem_read=0, mem_writedata=128'h1234; d_mem_busywait drops at done.
4. Simultaneous requests after reset: reqI and reqD in the same cycle → D granted first, I stalled (i_mem_busywait=1, mem_read driven with D's address); after D completes, I granted; order D,I,D,I for sustained dual requests.
5. Async reset mid-grant: reset=0 during GRANT_I with mem_busywait=1 → mem_read=0 immediately, state IDLE; after release, a pending reqI is re-granted.
6. Early mem_busywait low: memory holds busywait=0 on the first grant cycle then 1 for 3 cycles → no premature completion; done occurs only after the busy period.
